// File: rtl/rr_mux_pkg.sv
// Shared types for the 8-to-1 round-robin gather mux.
// Channel count, select width and output state encoding.
package rr_mux_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = $clog2(N_CH);

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        EMPTY,
        FULL
    } mux_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans ptr, ptr+1, ... modulo N and grants the first requester.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N = N_CH
) (
    input  logic [N-1:0] i_req,
    input  sel_t         i_ptr,
    input  logic         i_en,
    output logic [N-1:0] o_gnt,
    output sel_t         o_gnt_idx,
    output logic         o_any_gnt
);

    sel_t w_idx;

    // First valid channel at or after the pointer wins; wrap is free
    // because N equals 2**SEL_W.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any_gnt = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = i_ptr + sel_t'(k);
            if (i_en && !o_any_gnt && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_gnt_idx    = w_idx;
                o_any_gnt    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux8.sv
// Round-robin 8-to-1 channel mux with a single registered output.
// Output words carry their source channel on OUT_SEL.
module rr_mux8
    import rr_mux_pkg::*;
#(
    parameter int N = N_CH,
    parameter int W = 8
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic [N*W-1:0] IN_DATA,
    input  logic [N-1:0]   IN_VALID,
    output logic [N-1:0]   IN_READY,
    output logic [W-1:0]   OUT_DATA,
    output sel_t           OUT_SEL,
    output logic           OUT_VALID,
    input  logic           OUT_READY
);

    mux_state_t   r_state;
    logic [W-1:0] r_data;
    sel_t         r_sel;
    sel_t         r_ptr;

    logic         w_can_load;
    logic         w_en;
    logic [N-1:0] w_gnt;
    sel_t         w_gnt_idx;
    logic         w_any_gnt;

    // Load allowed when empty or the held word leaves this edge;
    // reset also blocks grants so no word is accepted while held low.
    always_comb begin
        w_can_load = (r_state == EMPTY) || OUT_READY;
        w_en       = w_can_load && RESET_N;
    end

    rr_arbiter #(
        .N(N)
    ) u_arb (
        .i_req    (IN_VALID),
        .i_ptr    (r_ptr),
        .i_en     (w_en),
        .o_gnt    (w_gnt),
        .o_gnt_idx(w_gnt_idx),
        .o_any_gnt(w_any_gnt)
    );

    // Output register, state and fairness pointer.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else if (w_any_gnt) begin
            r_data  <= IN_DATA[int'(w_gnt_idx)*W +: W];
            r_sel   <= w_gnt_idx;
            r_state <= FULL;
            r_ptr   <= w_gnt_idx + sel_t'(1);
        end else if (r_state == FULL && OUT_READY) begin
            r_state <= EMPTY;
        end
    end

    assign IN_READY  = w_gnt;
    assign OUT_DATA  = r_data;
    assign OUT_SEL   = r_sel;
    assign OUT_VALID = (r_state == FULL);

endmodule
